// File: rtl/debug_trace_buffer_pkg.sv
// ============================================================================
// debug_trace_buffer_pkg: shared mode/state encodings and timestamp width for
// the debug trace buffer.                                    Revision: 1.0
// ============================================================================
`default_nettype none

package debug_trace_buffer_pkg;

  localparam logic [1:0] MODE_CONT    = 2'b00;
  localparam logic [1:0] MODE_TRIG    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam int TS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_POST    = 3'd2,
    ST_DONE    = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/debug_trace_buffer_if.sv
// ============================================================================
// debug_trace_buffer_if: control, sample and readout signals of the trace
// buffer. Macro TRACE_TIMESTAMP_EN widens o_rd_data by TS_W.  Revision: 1.0
// ============================================================================
`default_nettype none

interface debug_trace_buffer_if
  import debug_trace_buffer_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 34,
  parameter int DEPTH  = 64
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SMP_W  = CH_NUM * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RD_W   = SMP_W + TS_W;
`else
  localparam int RD_W   = SMP_W;
`endif

  logic              i_arm;
  logic              i_stop;
  logic [1:0]        i_mode;
  logic              i_trig;
  logic [ADDR_W-1:0] i_post_cnt;
  logic              i_smp_valid;
  logic [SMP_W-1:0]  i_smp_data;
  logic              i_rd_req;
  logic              o_rd_valid;
  logic [RD_W-1:0]   o_rd_data;
  logic              o_rd_last;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W-1:0] o_wr_ptr;
  logic [ADDR_W-1:0] o_trig_idx;
  logic              o_wrapped;

  modport master (
    output i_arm, i_stop, i_mode, i_trig, i_post_cnt, i_smp_valid, i_smp_data, i_rd_req,
    input  o_rd_valid, o_rd_data, o_rd_last, o_busy, o_done, o_wr_ptr, o_trig_idx, o_wrapped
  );

  modport slave (
    input  i_arm, i_stop, i_mode, i_trig, i_post_cnt, i_smp_valid, i_smp_data, i_rd_req,
    output o_rd_valid, o_rd_data, o_rd_last, o_busy, o_done, o_wr_ptr, o_trig_idx, o_wrapped
  );

endinterface

`default_nettype wire

// File: rtl/debug_trace_buffer_trace_ram.sv
// ============================================================================
// trace_ram: simple dual-port RAM, one write port and one registered read
// port; contents and read register are not reset.            Revision: 1.0
// ============================================================================
`default_nettype none

module trace_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 136,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/debug_trace_buffer.sv
// ============================================================================
// debug_trace_buffer: circular trace capture (CONT/TRIG/ONESHOT) with
// oldest-first readout. Option macro: TRACE_TIMESTAMP_EN.    Revision: 1.0
// ============================================================================
`default_nettype none

module debug_trace_buffer
  import debug_trace_buffer_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 34,
  parameter int DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  debug_trace_buffer_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int SMP_W  = CH_NUM * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RD_W   = SMP_W + TS_W;
`else
  localparam int RD_W   = SMP_W;
`endif
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_trig_idx;
  logic [ADDR_W-1:0] r_remain;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_wrapped;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_data_ok;

  logic              w_capturing;
  logic              w_wr_en;
  logic              w_from_done;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_start;
  logic [ADDR_W-1:0] w_raddr;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_issue_idx;
  logic [RD_W-1:0]   w_wdata;
  logic [RD_W-1:0]   w_ram_q;

  assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_wr_en     = !bus.i_arm && w_capturing && bus.i_smp_valid;

  // Oldest entry sits at wr_ptr once the ring has wrapped, otherwise at 0.
  assign w_start     = r_wrapped ? r_wr_ptr : '0;
  assign w_count     = r_wrapped ? CNT_W'(DEPTH) : {1'b0, r_wr_ptr};
  assign w_from_done = (r_state == ST_DONE);
  assign w_raddr     = w_from_done ? w_start : r_rd_addr;
  assign w_issue_idx = w_from_done ? '0 : r_rd_cnt;
  assign w_rd_en     = !bus.i_arm && bus.i_rd_req && (w_count != '0) &&
                       (w_from_done || ((r_state == ST_READOUT) && (r_rd_cnt != w_count)));

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  assign w_wdata = {r_ts, bus.i_smp_data};
`else
  assign w_wdata = bus.i_smp_data;
`endif

  trace_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (RD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_trig_idx <= '0;
      r_remain   <= '0;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_wrapped  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_data_ok  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_rd_last  <= w_rd_en && (w_issue_idx == (w_count - CNT_W'(1)));
      if (w_rd_en) begin
        r_rd_addr <= w_raddr + ADDR_W'(1);
        r_rd_cnt  <= w_issue_idx + CNT_W'(1);
        r_data_ok <= 1'b1;
      end

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (r_wr_ptr == c_last_addr) r_wrapped <= 1'b1;
      end

      if (bus.i_arm) begin
        r_state    <= ST_CAPTURE;
        r_wr_ptr   <= '0;
        r_wrapped  <= 1'b0;
        r_trig_idx <= '0;
        r_remain   <= '0;
      end else begin
        case (r_state)
          ST_CAPTURE: begin
            if (bus.i_stop) begin
              r_state <= ST_DONE;
            end else if ((bus.i_mode == MODE_ONESHOT) && bus.i_smp_valid &&
                         (r_wr_ptr == c_last_addr)) begin
              r_state <= ST_DONE;
            end else if ((bus.i_mode == MODE_TRIG) && bus.i_trig && bus.i_smp_valid) begin
              r_trig_idx <= r_wr_ptr;
              r_remain   <= bus.i_post_cnt;
              r_state    <= (bus.i_post_cnt == '0) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            if (bus.i_stop) begin
              r_state <= ST_DONE;
            end else if (bus.i_smp_valid) begin
              r_remain <= r_remain - ADDR_W'(1);
              if (r_remain == ADDR_W'(1)) r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (w_rd_en) r_state <= ST_READOUT;
          end
          ST_READOUT: begin
            if (r_rd_cnt == w_count) r_state <= ST_DONE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // RAM read register has no reset; mask it until the first read after reset.
  assign bus.o_rd_data  = r_data_ok ? w_ram_q : '0;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_rd_last  = r_rd_last;
  assign bus.o_busy     = (r_state == ST_CAPTURE) || (r_state == ST_POST) ||
                          (r_state == ST_READOUT);
  assign bus.o_done     = (r_state == ST_DONE);
  assign bus.o_wr_ptr   = r_wr_ptr;
  assign bus.o_trig_idx = r_trig_idx;
  assign bus.o_wrapped  = r_wrapped;

endmodule

`default_nettype wire

// File: tb/tb_debug_trace_buffer.sv
// ============================================================================
// tb_debug_trace_buffer: randomized self-checking bench for debug_trace_buffer
// (DEPTH=8, CH_NUM=1, DATA_W=8).                              Revision: 1.0
// ============================================================================
`default_nettype none

module tb_debug_trace_buffer;

  localparam int DEPTH  = 8;
  localparam int CH_NUM = 1;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RD_W = CH_NUM * DATA_W + 16;
`else
  localparam int RD_W = CH_NUM * DATA_W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [RD_W-1:0] got_q[$];
  int              got_last;
  bit              rd_timeout;
  logic [7:0]      acc[$];
  logic [7:0]      exp_q[$];
  bit              pat4[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  debug_trace_buffer_if #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  debug_trace_buffer #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic tr, input logic st);
    bus.i_smp_valid = v;
    bus.i_smp_data  = d;
    bus.i_trig      = tr;
    bus.i_stop      = st;
    step();
    bus.i_smp_valid = 1'b0;
    bus.i_trig      = 1'b0;
    bus.i_stop      = 1'b0;
  endtask

  task automatic do_arm();
    bus.i_arm = 1'b1;
    step();
    bus.i_arm = 1'b0;
  endtask

  // Collects a readout: pat 0 = rd_req always, 1 = fixed gap pattern, 2 = random.
  task automatic read_all(input int pat);
    got_q.delete();
    got_last   = -1;
    rd_timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      case (pat)
        0:       bus.i_rd_req = 1'b1;
        1:       bus.i_rd_req = pat4[c % 7];
        default: bus.i_rd_req = 1'($urandom_range(0, 1));
      endcase
      step();
      if (bus.o_rd_valid) begin
        got_q.push_back(bus.o_rd_data);
        if (bus.o_rd_last) begin
          got_last   = got_q.size() - 1;
          rd_timeout = 1'b0;
        end
      end
      if (!rd_timeout) break;
    end
    bus.i_rd_req = 1'b0;
    repeat (4) begin
      step();
      if (bus.o_rd_valid) got_q.push_back(bus.o_rd_data);
    end
  endtask

  // Oldest-first view of the ring: the last DEPTH accepted samples.
  task automatic make_expected();
    exp_q = acc;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_wrapped, bus.o_rd_valid, bus.o_rd_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.o_busy, bus.o_done, bus.o_wrapped, bus.o_rd_valid, bus.o_rd_last});
    end
    checks++;
    if (bus.o_wr_ptr !== '0 || bus.o_trig_idx !== '0 || bus.o_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_values got wr_ptr=%0d trig_idx=%0d rd_data=%0h want 0",
               bus.o_wr_ptr, bus.o_trig_idx, bus.o_rd_data);
    end
  endtask

  task automatic test_oneshot();
    bus.i_mode = 2'b10;
    do_arm();
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_wr_ptr !== '0) begin
      errors++;
      $display("FAIL oneshot_arm got busy=%b wr_ptr=%0d want 1/0", bus.o_busy, bus.o_wr_ptr);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      if (k == 6) begin
        checks++;
        if (bus.o_done !== 1'b0) begin
          errors++;
          $display("FAIL oneshot_early_done got %b want 0", bus.o_done);
        end
      end
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_wrapped !== 1'b1 || bus.o_wr_ptr !== '0) begin
      errors++;
      $display("FAIL oneshot_done got done=%b wrapped=%b wr_ptr=%0d want 1/1/0",
               bus.o_done, bus.o_wrapped, bus.o_wr_ptr);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    checks++;
    if (bus.o_wr_ptr !== '0) begin
      errors++;
      $display("FAIL oneshot_ignore_done got wr_ptr=%0d want 0", bus.o_wr_ptr);
    end
    read_all(0);
    checks++;
    if (rd_timeout || got_q.size() != 8 || got_last != 7) begin
      errors++;
      $display("FAIL oneshot_read_count got n=%0d last=%0d timeout=%b want 8/7/0",
               got_q.size(), got_last, rd_timeout);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i][7:0] !== 8'(i)) begin
          errors++;
          $display("FAIL oneshot_read_data[%0d] got %0d want %0d", i, got_q[i][7:0], i);
        end
      end
    end
    // Random gaps and data; capture must end exactly at the DEPTH-th write.
    do_arm();
    acc.delete();
    while (acc.size() < DEPTH) begin
      logic v;
      logic [7:0] d;
      v = 1'($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      drive(v, d, 1'b0, 1'b0);
      if (v) acc.push_back(d);
      if (acc.size() < DEPTH) begin
        checks++;
        if (bus.o_done !== 1'b0) begin
          errors++;
          $display("FAIL oneshot_rand_early got done=%b after %0d samples", bus.o_done, acc.size());
        end
      end
    end
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_rand_done got %b want 1", bus.o_done);
    end
    make_expected();
    read_all(2);
    checks++;
    if (rd_timeout || got_q.size() != exp_q.size() || got_last != exp_q.size() - 1) begin
      errors++;
      $display("FAIL oneshot_rand_count got n=%0d last=%0d want %0d", got_q.size(), got_last,
               exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i][7:0] !== exp_q[i]) begin
          errors++;
          $display("FAIL oneshot_rand_data[%0d] got %0h want %0h", i, got_q[i][7:0], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_trig();
    bus.i_mode     = 2'b01;
    bus.i_post_cnt = 3'd2;
    do_arm();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'(k), k == 10, 1'b0);
      if (k == 11 || k == 12) begin
        checks++;
        if (bus.o_done !== (k == 12)) begin
          errors++;
          $display("FAIL trig_done_at_%0d got %b want %b", k, bus.o_done, k == 12);
        end
      end
    end
    checks++;
    if (bus.o_trig_idx !== 3'd2 || bus.o_wr_ptr !== 3'd5 || bus.o_wrapped !== 1'b1) begin
      errors++;
      $display("FAIL trig_ptrs got trig_idx=%0d wr_ptr=%0d wrapped=%b want 2/5/1",
               bus.o_trig_idx, bus.o_wr_ptr, bus.o_wrapped);
    end
    read_all(0);
    checks++;
    if (rd_timeout || got_q.size() != 8 || got_last != 7) begin
      errors++;
      $display("FAIL trig_read_count got n=%0d last=%0d want 8/7", got_q.size(), got_last);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i][7:0] !== 8'(i + 5)) begin
          errors++;
          $display("FAIL trig_read_data[%0d] got %0d want %0d", i, got_q[i][7:0], i + 5);
        end
      end
    end
    for (int it = 0; it < 4; it++) begin
      int p, n0, tidx;
      p  = $urandom_range(0, 7);
      n0 = $urandom_range(0, 15);
      bus.i_post_cnt = 3'(p);
      do_arm();
      acc.delete();
      while (acc.size() < n0) begin
        logic v;
        logic [7:0] d;
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        drive(v, d, !v && ($urandom_range(0, 1) == 1), 1'b0);
        if (v) acc.push_back(d);
      end
      begin
        logic [7:0] d;
        d = 8'($urandom);
        drive(1'b1, d, 1'b1, 1'b0);
        acc.push_back(d);
        tidx = (acc.size() - 1) % DEPTH;
      end
      for (int rem = p; rem > 0; ) begin
        logic v;
        logic [7:0] d;
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        drive(v, d, 1'($urandom_range(0, 1)), 1'b0);
        if (v) begin
          acc.push_back(d);
          rem--;
        end
      end
      checks++;
      if (bus.o_done !== 1'b1 || bus.o_trig_idx !== 3'(tidx) ||
          bus.o_wr_ptr !== 3'(acc.size() % DEPTH) || bus.o_wrapped !== (acc.size() >= DEPTH)) begin
        errors++;
        $display("FAIL trig_rand_state got done=%b trig_idx=%0d wr_ptr=%0d wrapped=%b want 1/%0d/%0d/%b",
                 bus.o_done, bus.o_trig_idx, bus.o_wr_ptr, bus.o_wrapped, tidx,
                 acc.size() % DEPTH, acc.size() >= DEPTH);
      end
      make_expected();
      read_all(2);
      checks++;
      if (rd_timeout || got_q.size() != exp_q.size() || got_last != exp_q.size() - 1) begin
        errors++;
        $display("FAIL trig_rand_count got n=%0d last=%0d want %0d", got_q.size(), got_last,
                 exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i][7:0] !== exp_q[i]) begin
            errors++;
            $display("FAIL trig_rand_data[%0d] got %0h want %0h", i, got_q[i][7:0], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_cont();
    bit seen;
    bus.i_mode = 2'b00;
    do_arm();
    drive(1'b1, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 8'd1, 1'b0, 1'b0);
    drive(1'b1, 8'd2, 1'b0, 1'b1);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_wrapped !== 1'b0 || bus.o_wr_ptr !== 3'd3) begin
      errors++;
      $display("FAIL cont_stop got done=%b wrapped=%b wr_ptr=%0d want 1/0/3",
               bus.o_done, bus.o_wrapped, bus.o_wr_ptr);
    end
    read_all(0);
    checks++;
    if (rd_timeout || got_q.size() != 3 || got_last != 2 || got_q[0][7:0] !== 8'd0 ||
        got_q[1][7:0] !== 8'd1 || got_q[2][7:0] !== 8'd2) begin
      errors++;
      $display("FAIL cont_read got n=%0d last=%0d want 3 entries 0,1,2 last=2", got_q.size(),
               got_last);
    end
    do_arm();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    seen = 1'b0;
    bus.i_rd_req = 1'b1;
    repeat (5) begin
      step();
      if (bus.o_rd_valid || !bus.o_done) seen = 1'b1;
    end
    bus.i_rd_req = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL cont_empty got rd_valid or left DONE want no readout");
    end
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(1, 20);
      bus.i_mode = (it == 1) ? 2'b11 : 2'b00;
      do_arm();
      acc.delete();
      while (acc.size() < n) begin
        logic v;
        logic [7:0] d;
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        drive(v, d, 1'b0, v && (acc.size() == n - 1));
        if (v) acc.push_back(d);
      end
      make_expected();
      read_all(0);
      checks++;
      if (rd_timeout || got_q.size() != exp_q.size() || got_last != exp_q.size() - 1) begin
        errors++;
        $display("FAIL cont_rand_count got n=%0d last=%0d want %0d", got_q.size(), got_last,
                 exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i][7:0] !== exp_q[i]) begin
            errors++;
            $display("FAIL cont_rand_data[%0d] got %0h want %0h", i, got_q[i][7:0], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    bus.i_mode = 2'b10;
    do_arm();
    acc.delete();
    for (int k = 0; k < DEPTH; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      drive(1'b1, d, 1'b0, 1'b0);
      acc.push_back(d);
    end
    make_expected();
    for (int pass = 0; pass < 2; pass++) begin
      read_all(pass == 0 ? 1 : 0);
      checks++;
      if (rd_timeout || got_q.size() != DEPTH || got_last != DEPTH - 1) begin
        errors++;
        $display("FAIL b2b_count pass %0d got n=%0d last=%0d want %0d", pass, got_q.size(),
                 got_last, DEPTH);
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          checks++;
          if (got_q[i][7:0] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_data pass %0d [%0d] got %0h want %0h", pass, i, got_q[i][7:0],
                     exp_q[i]);
          end
        end
      end
    end
    bus.i_rd_req = 1'b1;
    repeat (3) step();
    bus.i_rd_req = 1'b0;
    do_arm();
    seen = 1'b0;
    bus.i_rd_req = 1'b1;
    repeat (3) begin
      step();
      if (bus.o_rd_valid) seen = 1'b1;
    end
    bus.i_rd_req = 1'b0;
    checks++;
    if (seen || bus.o_busy !== 1'b1 || bus.o_wr_ptr !== '0) begin
      errors++;
      $display("FAIL abort_readout got rd_valid_seen=%b busy=%b wr_ptr=%0d want 0/1/0", seen,
               bus.o_busy, bus.o_wr_ptr);
    end
  endtask

  task automatic test_priority();
    bus.i_mode     = 2'b01;
    bus.i_post_cnt = 3'd0;
    do_arm();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL trig_no_valid got done=%b busy=%b want 0/1", bus.o_done, bus.o_busy);
    end
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_trig_idx !== 3'd0 || bus.o_wr_ptr !== 3'd1) begin
      errors++;
      $display("FAIL trig_post0 got done=%b trig_idx=%0d wr_ptr=%0d want 1/0/1", bus.o_done,
               bus.o_trig_idx, bus.o_wr_ptr);
    end
    bus.i_post_cnt = 3'd3;
    do_arm();
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b1, 1'b1);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_trig_idx !== 3'd0 || bus.o_wr_ptr !== 3'd2) begin
      errors++;
      $display("FAIL stop_over_trig got done=%b trig_idx=%0d wr_ptr=%0d want 1/0/2", bus.o_done,
               bus.o_trig_idx, bus.o_wr_ptr);
    end
    read_all(0);
    checks++;
    if (rd_timeout || got_q.size() != 2 || got_q[0][7:0] !== 8'hA1 || got_q[1][7:0] !== 8'hB2) begin
      errors++;
      $display("FAIL stop_trig_read got n=%0d want A1,B2", got_q.size());
    end
    bus.i_stop = 1'b1;
    do_arm();
    bus.i_stop = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0 || bus.o_wr_ptr !== '0) begin
      errors++;
      $display("FAIL arm_over_stop got busy=%b done=%b wr_ptr=%0d want 1/0/0", bus.o_busy,
               bus.o_done, bus.o_wr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_mode     = 2'b01;
    bus.i_post_cnt = 3'd5;
    do_arm();
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_wrapped, bus.o_rd_valid, bus.o_rd_last} !== 5'b0 ||
        bus.o_wr_ptr !== '0 || bus.o_trig_idx !== '0 || bus.o_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b wr_ptr=%0d trig_idx=%0d rd_data=%0h want all 0",
               bus.o_busy, bus.o_done, bus.o_wr_ptr, bus.o_trig_idx, bus.o_rd_data);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0/0", bus.o_busy, bus.o_done);
    end
    do_arm();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    checks++;
    if (bus.o_wr_ptr !== 3'd1 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rearm got wr_ptr=%0d busy=%b want 1/1", bus.o_wr_ptr, bus.o_busy);
    end
    drive(1'b1, 8'h88, 1'b0, 1'b1);
    read_all(0);
    checks++;
    if (rd_timeout || got_q.size() != 2 || got_q[0][7:0] !== 8'h77 || got_q[1][7:0] !== 8'h88) begin
      errors++;
      $display("FAIL rearm_read got n=%0d want 77,88", got_q.size());
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    bus.i_mode = 2'b00;
    do_arm();
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b1);
    read_all(0);
    checks++;
    if (rd_timeout || got_q.size() != 3) begin
      errors++;
      $display("FAIL ts_count got n=%0d want 3", got_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        logic [15:0] a, b;
        a = got_q[i-1][RD_W-1 -: 16];
        b = got_q[i][RD_W-1 -: 16];
        checks++;
        if (16'(b - a) !== 16'd1) begin
          errors++;
          $display("FAIL ts_delta[%0d] got %0d want 1", i, 16'(b - a));
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_arm       = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_mode      = 2'b00;
    bus.i_trig      = 1'b0;
    bus.i_post_cnt  = '0;
    bus.i_smp_valid = 1'b0;
    bus.i_smp_data  = '0;
    bus.i_rd_req    = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_oneshot();
    test_trig();
    test_cont();
    test_back_to_back();
    test_priority();
    test_reset_mid();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
